// File: rtl/epcs_rd_ctrl.sv
// EPCS serial flash read controller.
// Issues a READ (0x03) command with a 24-bit address over a mode-0 SPI link,
// then clocks in rd_len bytes and presents each as a one-cycle strobe.
// DCLK is derived from sys_clk by a HALF_DIV divider; chip select is held
// high for DESEL_CYC cycles after every transfer.
module epcs_rd_ctrl #(
  parameter int HALF_DIV  = 2,
  parameter int DESEL_CYC = 4
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic        rd_start,
  input  logic [23:0] rd_addr,
  input  logic [15:0] rd_len,
  output logic        rd_busy,
  output logic [7:0]  rd_data,
  output logic        rd_valid,
  output logic        rd_done,
  output logic        epcs_flash_dclk,
  output logic        epcs_flash_sce,
  output logic        epcs_flash_sdo,
  input  logic        epcs_flash_data0
);

  localparam int DIV_W = (HALF_DIV > 1) ? $clog2(HALF_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(HALF_DIV - 1);
  localparam int DSL_W = (DESEL_CYC > 1) ? $clog2(DESEL_CYC) : 1;
  localparam logic [DSL_W-1:0] DSL_LAST = DSL_W'(DESEL_CYC - 1);
  localparam logic [7:0] OP_READ = 8'h03;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CMD,
    S_ADDR,
    S_DATA,
    S_DESEL
  } state_t;

  state_t           state, state_nxt;
  logic             armed;      // blocks acceptance on the first edge after reset
  logic [DIV_W-1:0] div_cnt;
  logic             dclk_q;
  logic [4:0]       bit_cnt;    // 0..7 in CMD/DATA, 0..23 in ADDR
  logic [15:0]      byte_rem;   // bytes still to be received
  logic [31:0]      tx_sr;      // opcode + address, MSB leaves first
  logic [7:0]       rx_sr;
  logic [DSL_W-1:0] dsl_cnt;

  logic in_xfer, tick, rise, fall, accept, len_zero;

  assign in_xfer  = (state == S_CMD) || (state == S_ADDR) || (state == S_DATA);
  assign tick     = in_xfer && (div_cnt == DIV_LAST);
  assign rise     = tick && !dclk_q;
  assign fall     = tick && dclk_q;
  assign accept   = (state == S_IDLE) && armed && rd_start;
  assign len_zero = (rd_len == 16'd0);

  assign epcs_flash_dclk = dclk_q;

  // State register; reset aborts any transfer and raises sce immediately
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) state <= S_IDLE;
    else         state <= state_nxt;
  end

  // Next state and decoded outputs; sce/sdo/busy/done follow the state
  always_comb begin
    state_nxt      = state;
    rd_done        = 1'b0;
    epcs_flash_sce = 1'b1;
    epcs_flash_sdo = 1'b0;
    case (state)
      S_IDLE: begin
        if (accept) state_nxt = len_zero ? S_DESEL : S_CMD;
      end
      S_CMD: begin
        epcs_flash_sce = 1'b0;
        epcs_flash_sdo = tx_sr[31];
        if (fall && bit_cnt == 5'd7) state_nxt = S_ADDR;
      end
      S_ADDR: begin
        epcs_flash_sce = 1'b0;
        epcs_flash_sdo = tx_sr[31];
        if (fall && bit_cnt == 5'd23) state_nxt = S_DATA;
      end
      S_DATA: begin
        epcs_flash_sce = 1'b0;
        // last byte already counted on its 8th rising edge; close on the fall
        if (fall && byte_rem == 16'd0) state_nxt = S_DESEL;
      end
      S_DESEL: begin
        if (dsl_cnt == '0) begin
          rd_done   = 1'b1;
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
    rd_busy = (state != S_IDLE);
  end

  // Acceptance gate: one edge after reset release before rd_start counts
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) armed <= 1'b0;
    else         armed <= 1'b1;
  end

  // DCLK divider: low for HALF_DIV cycles after sce falls, then toggles
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      div_cnt <= '0;
      dclk_q  <= 1'b0;
    end else if (!in_xfer) begin
      div_cnt <= '0;
      dclk_q  <= 1'b0;
    end else if (tick) begin
      div_cnt <= '0;
      dclk_q  <= !dclk_q;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

  // Shift out opcode/address on falling DCLK, shift in data on rising DCLK
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      tx_sr    <= '0;
      rx_sr    <= '0;
      bit_cnt  <= '0;
      byte_rem <= '0;
      rd_data  <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= 1'b0;
      if (accept) begin
        tx_sr    <= {OP_READ, rd_addr};
        bit_cnt  <= '0;
        byte_rem <= rd_len;
      end else begin
        case (state)
          S_CMD: if (fall) begin
            tx_sr   <= {tx_sr[30:0], 1'b0};
            bit_cnt <= (bit_cnt == 5'd7) ? 5'd0 : bit_cnt + 5'd1;
          end
          S_ADDR: if (fall) begin
            tx_sr   <= {tx_sr[30:0], 1'b0};
            bit_cnt <= (bit_cnt == 5'd23) ? 5'd0 : bit_cnt + 5'd1;
          end
          S_DATA: if (rise) begin
            rx_sr <= {rx_sr[6:0], epcs_flash_data0};
            if (bit_cnt == 5'd7) begin
              rd_data  <= {rx_sr[6:0], epcs_flash_data0};
              rd_valid <= 1'b1;
              byte_rem <= byte_rem - 16'd1;
              bit_cnt  <= 5'd0;
            end else begin
              bit_cnt <= bit_cnt + 5'd1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  // Deselect hold: full DESEL_CYC after a transfer, single cycle for rd_len=0
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      dsl_cnt <= '0;
    end else if (accept) begin
      dsl_cnt <= '0;
    end else if (state == S_DATA && state_nxt == S_DESEL) begin
      dsl_cnt <= DSL_LAST;
    end else if (state == S_DESEL && dsl_cnt != '0) begin
      dsl_cnt <= dsl_cnt - 1'b1;
    end
  end

endmodule

// File: tb/tb_epcs_rd_ctrl.sv
// Bench for epcs_rd_ctrl: three instances (HALF_DIV 2, 1, 3) share one
// stimulus stream. Each has a flash model that decodes the command from sdo
// and answers from a fixed byte map, and a timeline model that derives every
// output from the request's cycle offset.
module tb_epcs_rd_ctrl;

  localparam int D = 4;

  logic        sys_clk = 1'b0;
  logic        sys_rst = 1'b1;
  logic        rd_start = 1'b0;
  logic [23:0] rd_addr = '0;
  logic [15:0] rd_len = '0;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always #5 sys_clk = ~sys_clk;

  // Current cycle index, read by the model before it advances
  always @(posedge sys_clk) cyc <= cyc + 1;

  function automatic logic [7:0] flash_byte(input logic [23:0] a);
    case (a)
      24'h012345: return 8'hA5;
      24'h012346: return 8'h5A;
      24'h012347: return 8'hFF;
      default:    return a[7:0] ^ {a[12:8], a[23:21]} ^ 8'h3C;
    endcase
  endfunction

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int H = (g == 0) ? 2 : (g == 1) ? 1 : 3;

    logic       busy, valid, done, dclk, sce, sdo;
    logic       d0 = 1'b0;
    logic [7:0] data;

    epcs_rd_ctrl #(.HALF_DIV(H), .DESEL_CYC(D)) u_dut (
      .sys_clk         (sys_clk),
      .sys_rst         (sys_rst),
      .rd_start        (rd_start),
      .rd_addr         (rd_addr),
      .rd_len          (rd_len),
      .rd_busy         (busy),
      .rd_data         (data),
      .rd_valid        (valid),
      .rd_done         (done),
      .epcs_flash_dclk (dclk),
      .epcs_flash_sce  (sce),
      .epcs_flash_sdo  (sdo),
      .epcs_flash_data0(d0)
    );

    // Flash: capture 32 command/address bits, then stream bytes on falling DCLK
    int          fr = 0;
    logic [31:0] fin = '0;
    always @(posedge sce or posedge dclk) begin
      if (sce) begin
        fr = 0;
        d0 = 1'b0;
      end else begin
        if (fr < 32) fin = {fin[30:0], sdo};
        fr++;
      end
    end
    always @(negedge dclk) begin
      int k;
      logic [7:0] b;
      if (!sce && fr >= 32) begin
        k  = fr - 32;
        b  = flash_byte(fin[23:0] + 24'(k / 8));
        d0 = b[3'(7 - k % 8)];
      end
    end

    // Request model: acceptance and the resulting busy window
    bit          t_act = 1'b0, armed = 1'b0;
    int          t_s = 0, t_end = 0, t_len = 0;
    logic [23:0] t_addr = '0;
    always @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
        t_act = 1'b0;
        armed = 1'b0;
      end else begin
        if (!(t_act && cyc <= t_end) && armed && rd_start) begin
          t_act  = 1'b1;
          t_s    = cyc + 1;
          t_len  = int'(rd_len);
          t_addr = rd_addr;
          t_end  = (rd_len == 16'd0) ? cyc + 1 : t_s + 2 * H * (32 + 8 * t_len) + D - 1;
        end
        armed = 1'b1;
      end
    end

    // Observed statistics for the literal checks
    int          nrise = 0, nvalid = 0, ndone = 0, per = 0, lrise = 0;
    int          hgap = 0, lastgap = 0;
    logic        pdclk = 1'b0;
    logic [23:0] rx3 = '0;

    // Per-cycle comparison against the timeline model
    always @(negedge sys_clk) begin
      logic [5:0]  ev, av;   // sce, dclk, sdo, busy, valid, done
      logic [7:0]  ed;
      logic [31:0] stream;
      bit          dchk;
      int          rel, p, ph;
      ev = 6'b100000;
      ed = 8'h00;
      dchk = sys_rst;
      if (!sys_rst && t_act && cyc >= t_s && cyc <= t_end) begin
        ev[2] = 1'b1;
        ev[0] = (cyc == t_end);
        if (t_len != 0) begin
          rel = cyc - t_s;
          if (rel < 2 * H * (32 + 8 * t_len)) begin
            p  = rel / (2 * H);
            ph = rel % (2 * H);
            stream = {8'h03, t_addr};
            ev[5] = 1'b0;
            ev[4] = (ph >= H);
            if (p < 32) ev[3] = stream[5'(31 - p)];
            else if ((p - 32) % 8 == 7 && ph == H) begin
              ev[1] = 1'b1;
              ed    = flash_byte(t_addr + 24'((p - 32) / 8));
              dchk  = 1'b1;
            end
          end
        end
      end
      av = {sce, dclk, sdo, busy, valid, done};
      checks++;
      if (av !== ev) begin
        errors++;
        $display("FAIL H%0d cyc %0d outputs {sce,dclk,sdo,busy,valid,done}: got %b expected %b",
                 H, cyc, av, ev);
      end
      if (dchk) begin
        checks++;
        if (data !== ed) begin
          errors++;
          $display("FAIL H%0d cyc %0d rd_data: got %h expected %h", H, cyc, data, ed);
        end
      end
      if (dclk && !pdclk) begin
        nrise++;
        per   = cyc - lrise;
        lrise = cyc;
      end
      pdclk = dclk;
      if (valid) begin
        nvalid++;
        rx3 = {rx3[15:0], data};
      end
      if (done) ndone++;
      if (sce) hgap++;
      else begin
        if (hgap > 0) lastgap = hgap;
        hgap = 0;
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic issue(input logic [23:0] a, input logic [15:0] l);
    @(posedge sys_clk); #1;
    rd_start = 1'b1; rd_addr = a; rd_len = l;
    @(posedge sys_clk); #1;
    rd_start = 1'b0; rd_addr = 24'($urandom); rd_len = 16'($urandom);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    repeat (2) @(negedge sys_clk);
    while ((g_dut[0].busy || g_dut[1].busy || g_dut[2].busy) && n < 5000) begin
      @(negedge sys_clk);
      n++;
    end
    checks++;
    if (n >= 5000) begin
      errors++;
      $display("FAIL idle_timeout: got busy after %0d cycles expected idle", n);
    end
    repeat (2) @(negedge sys_clk);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int r0, r1, r2, d0s, d1s, d2s, v0, n;
    repeat (3) @(posedge sys_clk);
    #1 sys_rst = 1'b0;
    repeat (3) @(posedge sys_clk);

    // Reference transfer: bytes A5 5A FF from 0x012345
    r0 = g_dut[0].nrise; d0s = g_dut[0].ndone;
    issue(24'h012345, 16'd3);
    wait_idle();
    chk("ref_bytes", {8'h00, g_dut[0].rx3}, 32'h00A55AFF);
    chk("ref_cmd_addr", g_dut[0].fin, 32'h03012345);
    chk("ref_rises", g_dut[0].nrise - r0, 56);
    chk("ref_done", g_dut[0].ndone - d0s, 1);

    // Divider extremes, one byte
    r1 = g_dut[1].nrise; r2 = g_dut[2].nrise;
    issue(24'h012346, 16'd1);
    wait_idle();
    chk("h1_period", g_dut[1].per, 2);
    chk("h3_period", g_dut[2].per, 6);
    chk("h1_rises", g_dut[1].nrise - r1, 40);
    chk("h3_rises", g_dut[2].nrise - r2, 40);
    chk("h1_byte", {24'h0, g_dut[1].rx3[7:0]}, 32'h5A);
    chk("h3_byte", {24'h0, g_dut[2].rx3[7:0]}, 32'h5A);

    // Zero length: no DCLK, single done
    r0 = g_dut[0].nrise; d0s = g_dut[0].ndone;
    issue(24'hABCDEF, 16'd0);
    wait_idle();
    chk("len0_rises", g_dut[0].nrise - r0, 0);
    chk("len0_done", g_dut[0].ndone - d0s, 1);

    // rd_start during ADDR is ignored
    d0s = g_dut[0].ndone; d1s = g_dut[1].ndone; d2s = g_dut[2].ndone;
    issue(24'h5A0F33, 16'd2);
    repeat (50) @(posedge sys_clk);
    issue(24'h123456, 16'd3);
    wait_idle();
    chk("ign_addr_h2", g_dut[0].fin, 32'h035A0F33);
    chk("ign_addr_h1", g_dut[1].fin, 32'h035A0F33);
    chk("ign_addr_h3", g_dut[2].fin, 32'h035A0F33);
    chk("ign_done_h2", g_dut[0].ndone - d0s, 1);
    chk("ign_done_h1", g_dut[1].ndone - d1s, 1);
    chk("ign_done_h3", g_dut[2].ndone - d2s, 1);

    // Reset after the second byte aborts silently
    d0s = g_dut[0].ndone; v0 = g_dut[0].nvalid;
    issue(24'h00FF00, 16'd4);
    n = 0;
    while (g_dut[0].nvalid - v0 < 2 && n < 3000) begin
      @(negedge sys_clk);
      n++;
    end
    chk("abort_reach_byte2", g_dut[0].nvalid - v0, 2);
    @(posedge sys_clk); #2 sys_rst = 1'b1;
    #1;
    chk("abort_sce_h2", {31'h0, g_dut[0].sce}, 1);
    chk("abort_sce_h1", {31'h0, g_dut[1].sce}, 1);
    chk("abort_sce_h3", {31'h0, g_dut[2].sce}, 1);
    chk("abort_busy", {31'h0, g_dut[0].busy}, 0);
    @(posedge sys_clk); #1 sys_rst = 1'b0;
    repeat (3) @(posedge sys_clk);
    chk("abort_no_done", g_dut[0].ndone - d0s, 0);
    chk("abort_no_valid", g_dut[0].nvalid - v0, 2);
    issue(24'h012345, 16'd3);
    wait_idle();
    chk("after_abort_bytes", {8'h00, g_dut[0].rx3}, 32'h00A55AFF);

    // Back-to-back: start issued in the cycle after rd_done
    issue(24'h000010, 16'd1);
    n = 0;
    @(negedge sys_clk);
    while (!g_dut[0].done && n < 3000) begin
      @(negedge sys_clk);
      n++;
    end
    chk("b2b_done_seen", {31'h0, g_dut[0].done}, 1);
    issue(24'h000020, 16'd1);
    repeat (3) @(negedge sys_clk);
    chk("b2b_gap", g_dut[0].lastgap, 5);
    wait_idle();
    chk("b2b_addr", g_dut[0].fin, 32'h03000020);

    // Randomized requests, some landing while instances are still busy
    for (int i = 0; i < 25; i++) begin
      issue(24'($urandom), 16'($urandom_range(0, 4)));
      repeat ($urandom_range(0, 150)) @(posedge sys_clk);
    end
    wait_idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
